// File: rtl/binary_to_bcd_encoder.sv
// binary_to_bcd_encoder: sequential double-dabble converter, one iteration per clock, flags aligned with digits
`timescale 1ns/1ps
module binary_to_bcd_encoder #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] Binary,
    input  logic             ovf_in,
    input  logic             carry_in,
    output logic             busy,
    output logic             valid,
    output logic [3:0]       Units,
    output logic [3:0]       Tens,
    output logic [1:0]       Hundreds,
    output logic             Zero,
    output logic             Overflow,
    output logic             Carry_out
);
    typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;
    localparam logic [3:0] LAST = 4'(WIDTH - 1);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [9:0]       bcd_q, bcd_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             zl_q, zl_d, ol_q, ol_d, cl_q, cl_d;
    logic [3:0]       units_q, units_d, tens_q, tens_d;
    logic [1:0]       hund_q, hund_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, carry_q, carry_d, valid_q, valid_d;
    logic [3:0]       u_fix, t_fix;
    // Next-state: capture in IDLE, add-3 then shift in CONVERT, publish digits and flags in FINISH
    always_comb begin
        u_fix   = bcd_q[3:0] >= 4'd5 ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
        t_fix   = bcd_q[7:4] >= 4'd5 ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        zl_d    = zl_q;
        ol_d    = ol_q;
        cl_d    = cl_q;
        units_d = units_q;
        tens_d  = tens_q;
        hund_d  = hund_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        carry_d = carry_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                bin_d   = Binary;
                bcd_d   = 10'd0;
                cnt_d   = 4'd0;
                zl_d    = Binary == '0;
                ol_d    = ovf_in;
                cl_d    = carry_in;
                state_d = CONVERT;
            end
            CONVERT: begin
                bcd_d   = {bcd_q[8], t_fix, u_fix, bin_q[WIDTH-1]};
                bin_d   = bin_q << 1;
                cnt_d   = cnt_q + 4'd1;
                state_d = cnt_q == LAST ? FINISH : CONVERT;
            end
            FINISH: begin
                units_d = bcd_q[3:0];
                tens_d  = bcd_q[7:4];
                hund_d  = bcd_q[9:8];
                zero_d  = zl_q;
                ovf_d   = ol_q;
                carry_d = cl_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // State and result registers; reset returns the display to zero with Zero set
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            zl_q    <= 1'b0;
            ol_q    <= 1'b0;
            cl_q    <= 1'b0;
            units_q <= '0;
            tens_q  <= '0;
            hund_q  <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            zl_q    <= zl_d;
            ol_q    <= ol_d;
            cl_q    <= cl_d;
            units_q <= units_d;
            tens_q  <= tens_d;
            hund_q  <= hund_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end
    assign busy      = state_q != IDLE;
    assign valid     = valid_q;
    assign Units     = units_q;
    assign Tens      = tens_q;
    assign Hundreds  = hund_q;
    assign Zero      = zero_q;
    assign Overflow  = ovf_q;
    assign Carry_out = carry_q;
endmodule
